// File: rtl/divisor_secuencial_if.sv
// Request/result bundle of the sequential restoring divider.
// The testbench drives through the master side; the divider uses the slave side.
interface divisor_secuencial_if #(
    parameter int N = 24
) ();
    logic           start;
    logic [2*N-1:0] dividendo;
    logic [N-1:0]   divisor;
    logic           busy;
    logic           done;
    logic [N-1:0]   cociente;
    logic [N-1:0]   residuo;
    logic           desborde;
    logic           div_cero;

    modport master (
        output start, dividendo, divisor,
        input  busy, done, cociente, residuo, desborde, div_cero
    );

    modport slave (
        input  start, dividendo, divisor,
        output busy, done, cociente, residuo, desborde, div_cero
    );
endinterface

// File: rtl/divisor_secuencial.sv
// Iterative restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Optional round-to-nearest on completion when DIV_ROUND_EN is defined.
module divisor_secuencial #(
    parameter int N = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    divisor_secuencial_if.slave  bus
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    r_q, r_d;
    logic [N-1:0]    dvd_q, dvd_d;
    logic [N-1:0]    dsr_q, dsr_d;
    logic [N-2:0]    q_q, q_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    cociente_q, cociente_d;
    logic [N-1:0]    residuo_q, residuo_d;
    logic            desborde_q, desborde_d;
    logic            div_cero_q, div_cero_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [N:0]      r_shift_s;
    logic [N:0]      diff_s;
    logic            ge_s;
    logic [N-1:0]    r_step_s;
    logic [N-1:0]    q_step_s;

    // One restoring step; r_shift < 2*divisor, so the borrow bit alone decides R >= divisor.
    assign r_shift_s = {r_q, dvd_q[N-1]};
    assign diff_s    = r_shift_s - {1'b0, dsr_q};
    assign ge_s      = ~diff_s[N];
    assign r_step_s  = ge_s ? diff_s[N-1:0] : r_shift_s[N-1:0];
    assign q_step_s  = {q_q, ge_s};

`ifdef DIV_ROUND_EN
    logic            round_up_s;
    logic            q_full_s;
    assign round_up_s = {r_step_s, 1'b0} >= {1'b0, dsr_q};
    assign q_full_s   = &q_step_s;
`endif

    // Next-state and datapath control for IDLE / CALC / DONE.
    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        dvd_d      = dvd_q;
        dsr_d      = dsr_q;
        q_d        = q_q;
        cnt_d      = cnt_q;
        cociente_d = cociente_q;
        residuo_d  = residuo_q;
        desborde_d = desborde_q;
        div_cero_d = div_cero_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    dvd_d      = bus.dividendo[N-1:0];
                    dsr_d      = bus.divisor;
                    desborde_d = 1'b0;
                    div_cero_d = 1'b0;
                    if (bus.divisor == '0) begin
                        div_cero_d = 1'b1;
                        cociente_d = '1;
                        residuo_d  = bus.dividendo[N-1:0];
                        state_d    = DONE;
                    end else if (bus.dividendo[2*N-1:N] >= bus.divisor) begin
                        desborde_d = 1'b1;
                        cociente_d = '1;
                        residuo_d  = bus.dividendo[N-1:0];
                        state_d    = DONE;
                    end else begin
                        r_d     = bus.dividendo[2*N-1:N];
                        q_d     = '0;
                        cnt_d   = CW'(N-1);
                        busy_d  = 1'b1;
                        state_d = CALC;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                r_d   = r_step_s;
                dvd_d = {dvd_q[N-2:0], 1'b0};
                q_d   = q_step_s[N-2:0];
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
`ifdef DIV_ROUND_EN
                    if (round_up_s) begin
                        if (q_full_s) begin
                            cociente_d = '1;
                            desborde_d = 1'b1;
                        end else begin
                            cociente_d = q_step_s + N'(1);
                        end
                        residuo_d = dsr_q - r_step_s;
                    end else begin
                        cociente_d = q_step_s;
                        residuo_d  = r_step_s;
                    end
`else
                    cociente_d = q_step_s;
                    residuo_d  = r_step_s;
`endif
                end else begin
                    state_d = CALC;
                    busy_d  = 1'b1;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            r_q        <= '0;
            dvd_q      <= '0;
            dsr_q      <= '0;
            q_q        <= '0;
            cnt_q      <= '0;
            cociente_q <= '0;
            residuo_q  <= '0;
            desborde_q <= 1'b0;
            div_cero_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            dvd_q      <= dvd_d;
            dsr_q      <= dsr_d;
            q_q        <= q_d;
            cnt_q      <= cnt_d;
            cociente_q <= cociente_d;
            residuo_q  <= residuo_d;
            desborde_q <= desborde_d;
            div_cero_q <= div_cero_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.cociente = cociente_q;
    assign bus.residuo  = residuo_q;
    assign bus.desborde = desborde_q;
    assign bus.div_cero = div_cero_q;
endmodule
